// File: rtl/dcache_wb_buffer_pkg.sv
// Shared types for the Dcache write-back buffer: bus commands, victim address layout,
// buffer entry payload and drain FSM states.
package dcache_wb_buffer_pkg;

    localparam int unsigned WB_DEPTH = 4;
    localparam int unsigned PTR_W    = $clog2(WB_DEPTH);
    localparam int unsigned DATA_W   = 64;

    typedef enum logic [1:0] {
        BUS_NONE  = 2'h0,
        BUS_LOAD  = 2'h1,
        BUS_STORE = 2'h2
    } BUS_COMMAND;

    // 8-byte lines: low 3 bits are byte offset and never take part in a match
    typedef struct packed {
        logic [55:0] tag;
        logic [4:0]  set_index;
        logic [2:0]  ignore;
    } SASS_ADDR;

    typedef struct packed {
        logic              valid;
        SASS_ADDR          addr;
        logic [DATA_W-1:0] data;
    } WB_ENTRY_t;

    typedef enum logic {
        WB_IDLE = 1'b0,
        WB_REQ  = 1'b1
    } WB_STATE_t;

    function automatic logic line_match(input SASS_ADDR a, input SASS_ADDR b);
        return (a.tag == b.tag) && (a.set_index == b.set_index);
    endfunction

endpackage

// File: rtl/dcache_wb_buffer_age_match.sv
// Picks the youngest matching entry of the circular buffer as a one-hot select.
module wb_age_match
    import dcache_wb_buffer_pkg::*;
(
    input  logic [WB_DEPTH-1:0] i_match,
    input  logic [PTR_W-1:0]    i_tail,
    output logic [WB_DEPTH-1:0] o_sel
);

    logic [PTR_W-1:0] w_idx;

    // Walk from tail (oldest slot) towards tail-1 (youngest); the last hit wins.
    always_comb begin
        o_sel = '0;
        w_idx = '0;
        for (int k = 0; k < int'(WB_DEPTH); k++) begin
            w_idx = i_tail + PTR_W'(k);
            if (i_match[w_idx]) begin
                o_sel        = '0;
                o_sel[w_idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dcache_wb_buffer.sv
// Write-back buffer for dirty Dcache victims: FIFO drain to memory as BUS_STORE,
// load-miss forwarding of the youngest buffered copy, and flush completion status.
module dcache_wb_buffer
    import dcache_wb_buffer_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              evict_push,
    input  SASS_ADDR          evict_addr,
    input  logic [DATA_W-1:0] evict_data,
    output logic              full,
    output logic              empty,
    output logic [PTR_W:0]    count,
    input  logic              rd_search,
    input  SASS_ADDR          rd_addr,
    output logic              rd_hit,
    output logic [DATA_W-1:0] rd_data,
    input  logic              mem_grant,
    output BUS_COMMAND        proc2mem_command,
    output logic [63:0]       proc2mem_addr,
    output logic [DATA_W-1:0] proc2mem_data,
    input  logic [3:0]        mem2proc_response,
    input  logic              flush,
    output logic              flush_done
);

    WB_ENTRY_t        r_entries [WB_DEPTH];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [PTR_W:0]   r_count;
    WB_STATE_t        r_state;
    logic             r_flush_done;

    logic [WB_DEPTH-1:0] w_fwd_match, w_fwd_sel;
    logic [WB_DEPTH-1:0] w_merge_match, w_merge_sel;
    logic                w_push, w_merge, w_alloc, w_pop, w_sending;
    logic [PTR_W:0]      w_count_next;
    logic [DATA_W-1:0]   w_fwd_data;

    // The head being offered to memory is frozen; a new copy of it must go to a fresh slot.
    always_comb begin
        w_fwd_match   = '0;
        w_merge_match = '0;
        for (int i = 0; i < int'(WB_DEPTH); i++) begin
            w_fwd_match[i]   = r_entries[i].valid && line_match(r_entries[i].addr, rd_addr);
            w_merge_match[i] = r_entries[i].valid && line_match(r_entries[i].addr, evict_addr)
                               && !((r_state == WB_REQ) && (PTR_W'(i) == r_head));
        end
    end

    wb_age_match u_fwd_age (
        .i_match (w_fwd_match),
        .i_tail  (r_tail),
        .o_sel   (w_fwd_sel)
    );

    wb_age_match u_merge_age (
        .i_match (w_merge_match),
        .i_tail  (r_tail),
        .o_sel   (w_merge_sel)
    );

    always_comb begin
        w_fwd_data = '0;
        for (int i = 0; i < int'(WB_DEPTH); i++) begin
            if (w_fwd_sel[i]) w_fwd_data = w_fwd_data | r_entries[i].data;
        end
    end

    assign full         = (r_count == (PTR_W+1)'(WB_DEPTH));
    assign empty        = (r_count == '0);
    assign count        = r_count;
    assign w_push       = evict_push && !full;
    assign w_merge      = |w_merge_sel;
    assign w_alloc      = w_push && !w_merge;
    assign w_sending    = (r_state == WB_REQ) && mem_grant;
    assign w_pop        = w_sending && (mem2proc_response != 4'd0);
    assign w_count_next = r_count + (PTR_W+1)'(w_alloc) - (PTR_W+1)'(w_pop);

    assign rd_hit           = rd_search && (|w_fwd_sel);
    assign rd_data          = rd_hit ? w_fwd_data : '0;
    assign proc2mem_command = w_sending ? BUS_STORE : BUS_NONE;
    assign proc2mem_addr    = w_sending ? 64'(r_entries[r_head].addr) : 64'd0;
    assign proc2mem_data    = w_sending ? r_entries[r_head].data : '0;
    assign flush_done       = r_flush_done;

    // Entry storage, pointers and drain FSM.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < int'(WB_DEPTH); i++) r_entries[i] <= '0;
            r_head       <= '0;
            r_tail       <= '0;
            r_count      <= '0;
            r_state      <= WB_IDLE;
            r_flush_done <= 1'b0;
        end else begin
            for (int i = 0; i < int'(WB_DEPTH); i++) begin
                if (w_pop && (PTR_W'(i) == r_head)) r_entries[i].valid <= 1'b0;
                if (w_push && w_merge_sel[i]) r_entries[i].data <= evict_data;
                if (w_alloc && (PTR_W'(i) == r_tail)) begin
                    r_entries[i].valid <= 1'b1;
                    r_entries[i].addr  <= evict_addr;
                    r_entries[i].data  <= evict_data;
                end
            end
            if (w_pop)   r_head <= r_head + 1'b1;
            if (w_alloc) r_tail <= r_tail + 1'b1;
            r_count <= w_count_next;

            case (r_state)
                WB_IDLE: if (r_count != '0) r_state <= WB_REQ;
                WB_REQ:  if (w_pop) r_state <= (w_count_next != '0) ? WB_REQ : WB_IDLE;
                default: r_state <= WB_IDLE;
            endcase

            r_flush_done <= flush && (r_count == '0) && (r_state == WB_IDLE) && !evict_push;
        end
    end

endmodule

// File: tb/tb_dcache_wb_buffer.sv
// Directed bench for dcache_wb_buffer: push/drain, wrap, merge, forwarding, reset and flush.
module tb_dcache_wb_buffer;
    import dcache_wb_buffer_pkg::*;

    logic              clock = 1'b0;
    logic              reset;
    logic              evict_push;
    logic [63:0]       evict_addr;
    logic [63:0]       evict_data;
    logic              full, empty;
    logic [PTR_W:0]    count;
    logic              rd_search;
    logic [63:0]       rd_addr;
    logic              rd_hit;
    logic [63:0]       rd_data;
    logic              mem_grant;
    BUS_COMMAND        proc2mem_command;
    logic [63:0]       proc2mem_addr;
    logic [63:0]       proc2mem_data;
    logic [3:0]        mem2proc_response;
    logic              flush;
    logic              flush_done;

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    dcache_wb_buffer dut (
        .clock             (clock),
        .reset             (reset),
        .evict_push        (evict_push),
        .evict_addr        (evict_addr),
        .evict_data        (evict_data),
        .full              (full),
        .empty             (empty),
        .count             (count),
        .rd_search         (rd_search),
        .rd_addr           (rd_addr),
        .rd_hit            (rd_hit),
        .rd_data           (rd_data),
        .mem_grant         (mem_grant),
        .proc2mem_command  (proc2mem_command),
        .proc2mem_addr     (proc2mem_addr),
        .proc2mem_data     (proc2mem_data),
        .mem2proc_response (mem2proc_response),
        .flush             (flush),
        .flush_done        (flush_done)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic set_push(input logic [63:0] a, input logic [63:0] d);
        evict_push = 1'b1;
        evict_addr = a;
        evict_data = d;
    endtask

    // Upstream must never push into a full buffer.
    always @(negedge clock) begin
        if (!reset && evict_push) begin
            assert (!full) else begin
                errors++;
                $error("FAIL push_while_full observed=1 expected=0");
            end
        end
    end

    initial begin
        reset = 1'b1; evict_push = 1'b0; evict_addr = '0; evict_data = '0;
        rd_search = 1'b0; rd_addr = '0; mem_grant = 1'b0; mem2proc_response = '0; flush = 1'b0;
        step(); step();
        reset = 1'b0;

        // 1: reset state then idle
        mem_grant = 1'b1;
        for (int i = 0; i < 5; i++) step();
        rd_search = 1'b1; rd_addr = 64'h0; #1;
        chk("t1_empty", 64'(empty), 64'd1);
        chk("t1_full", 64'(full), 64'd0);
        chk("t1_count", 64'(count), 64'd0);
        chk("t1_cmd", 64'(proc2mem_command), 64'(BUS_NONE));
        chk("t1_rd_hit", 64'(rd_hit), 64'd0);
        chk("t1_flush_done", 64'(flush_done), 64'd0);
        rd_search = 1'b0;

        // 2: single store held until response, grant gating
        set_push(64'h1000, 64'hAAAA); mem2proc_response = 4'd0;
        step(); evict_push = 1'b0;
        chk("t2_count_push", 64'(count), 64'd1);
        chk("t2_cmd_latency", 64'(proc2mem_command), 64'(BUS_NONE));
        rd_search = 1'b1; rd_addr = 64'h1000; #1;
        chk("t2_fwd_hit", 64'(rd_hit), 64'd1);
        chk("t2_fwd_data", rd_data, 64'hAAAA);
        rd_search = 1'b0;
        step();
        for (int i = 0; i < 3; i++) begin
            chk("t2_cmd_hold", 64'(proc2mem_command), 64'(BUS_STORE));
            chk("t2_addr_hold", proc2mem_addr, 64'h1000);
            chk("t2_data_hold", proc2mem_data, 64'hAAAA);
            step();
        end
        chk("t2_count_no_resp", 64'(count), 64'd1);
        mem_grant = 1'b0; mem2proc_response = 4'd5; #1;
        chk("t2_cmd_nogrant", 64'(proc2mem_command), 64'(BUS_NONE));
        chk("t2_addr_nogrant", proc2mem_addr, 64'h0);
        step();
        chk("t2_resp_ignored", 64'(count), 64'd1);
        mem_grant = 1'b1; #1;
        chk("t2_cmd_regrant", 64'(proc2mem_command), 64'(BUS_STORE));
        step(); mem2proc_response = 4'd0;
        chk("t2_empty_pop", 64'(empty), 64'd1);
        chk("t2_count_pop", 64'(count), 64'd0);
        chk("t2_cmd_idle", 64'(proc2mem_command), 64'(BUS_NONE));

        // 3: fill to full, forward, drain in order with pointer wrap
        mem_grant = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_push(64'h2000 + 64'(8 * i), 64'hB0 + 64'(i));
            step();
        end
        evict_push = 1'b0;
        chk("t3_full", 64'(full), 64'd1);
        chk("t3_count", 64'(count), 64'd4);
        rd_search = 1'b1; rd_addr = 64'h2010; #1;
        chk("t3_fwd_hit", 64'(rd_hit), 64'd1);
        chk("t3_fwd_data", rd_data, 64'hB2);
        rd_addr = 64'h2014; #1;
        chk("t3_fwd_offset_hit", 64'(rd_hit), 64'd1);
        chk("t3_fwd_offset_data", rd_data, 64'hB2);
        rd_addr = 64'h2020; #1;
        chk("t3_miss_hit", 64'(rd_hit), 64'd0);
        chk("t3_miss_data", rd_data, 64'h0);
        rd_search = 1'b0; rd_addr = 64'h2010; #1;
        chk("t3_nosearch_hit", 64'(rd_hit), 64'd0);
        mem_grant = 1'b1; mem2proc_response = 4'd1; #1;
        chk("t3_drain0_addr", proc2mem_addr, 64'h2000);
        chk("t3_drain0_data", proc2mem_data, 64'hB0);
        step();
        chk("t3_full_after_pop", 64'(full), 64'd0);
        chk("t3_count_after_pop", 64'(count), 64'd3);
        set_push(64'h4000, 64'hE0); #1;
        chk("t3_drain1_addr", proc2mem_addr, 64'h2008);
        step(); evict_push = 1'b0;
        chk("t3_count_pushpop", 64'(count), 64'd3);
        chk("t3_drain2_addr", proc2mem_addr, 64'h2010);
        chk("t3_drain2_data", proc2mem_data, 64'hB2);
        step();
        chk("t3_drain3_addr", proc2mem_addr, 64'h2018);
        step();
        chk("t3_drain4_addr", proc2mem_addr, 64'h4000);
        chk("t3_drain4_data", proc2mem_data, 64'hE0);
        step();
        chk("t3_empty", 64'(empty), 64'd1);
        mem_grant = 1'b0; mem2proc_response = 4'd0;

        // 4: merge into idle entry, no merge into in-flight head
        set_push(64'h1000, 64'h11); step();
        set_push(64'h1000, 64'h22); step(); evict_push = 1'b0;
        chk("t4_merge_count", 64'(count), 64'd1);
        mem_grant = 1'b1; #1;
        chk("t4_merge_data", proc2mem_data, 64'h22);
        mem2proc_response = 4'd1;
        step(); mem2proc_response = 4'd0; mem_grant = 1'b0;
        chk("t4_merge_empty", 64'(empty), 64'd1);
        set_push(64'h1000, 64'h11); step(); evict_push = 1'b0;
        step();
        set_push(64'h1000, 64'h22); step(); evict_push = 1'b0;
        chk("t4_inflight_count", 64'(count), 64'd2);
        rd_search = 1'b1; rd_addr = 64'h1000; #1;
        chk("t4_fwd_youngest", rd_data, 64'h22);
        mem_grant = 1'b1; #1;
        chk("t4_store_old", proc2mem_data, 64'h11);
        mem2proc_response = 4'd1;
        step();
        chk("t4_count_pop1", 64'(count), 64'd1);
        chk("t4_fwd_after_pop", rd_data, 64'h22);
        chk("t4_store_new", proc2mem_data, 64'h22);
        step();
        chk("t4_empty", 64'(empty), 64'd1);
        chk("t4_fwd_gone", 64'(rd_hit), 64'd0);
        rd_search = 1'b0; mem_grant = 1'b0; mem2proc_response = 4'd0;

        // 5: push+pop at count 2, then reset during REQ
        set_push(64'h5000, 64'h50); step();
        set_push(64'h5008, 64'h51); step(); evict_push = 1'b0;
        chk("t5_count2", 64'(count), 64'd2);
        mem_grant = 1'b1; mem2proc_response = 4'd1;
        set_push(64'h5010, 64'h52); #1;
        chk("t5_head0", proc2mem_data, 64'h50);
        step(); evict_push = 1'b0;
        chk("t5_count_same", 64'(count), 64'd2);
        chk("t5_head1", proc2mem_data, 64'h51);
        step();
        chk("t5_count1", 64'(count), 64'd1);
        chk("t5_head2", proc2mem_data, 64'h52);
        mem2proc_response = 4'd0;
        reset = 1'b1;
        step(); reset = 1'b0;
        chk("t5_rst_count", 64'(count), 64'd0);
        chk("t5_rst_empty", 64'(empty), 64'd1);
        chk("t5_rst_cmd", 64'(proc2mem_command), 64'(BUS_NONE));
        rd_search = 1'b1; rd_addr = 64'h5010; #1;
        chk("t5_rst_fwd", 64'(rd_hit), 64'd0);
        rd_search = 1'b0;
        step();
        chk("t5_no_retry_cmd", 64'(proc2mem_command), 64'(BUS_NONE));
        chk("t5_no_retry_count", 64'(count), 64'd0);

        // 6: flush drains three entries with toggling grant
        flush = 1'b1; mem_grant = 1'b0; mem2proc_response = 4'd1;
        for (int i = 0; i < 3; i++) begin
            set_push(64'h6000 + 64'(8 * i), 64'h60 + 64'(i));
            step();
            chk("t6_fd_push", 64'(flush_done), 64'd0);
        end
        evict_push = 1'b0;
        for (int i = 0; i < 5; i++) begin
            mem_grant = (i % 2 == 0);
            step();
            chk("t6_fd_draining", 64'(flush_done), 64'd0);
        end
        chk("t6_empty", 64'(empty), 64'd1);
        mem_grant = 1'b0; mem2proc_response = 4'd0;
        step();
        chk("t6_fd_set", 64'(flush_done), 64'd1);
        flush = 1'b0;
        step();
        chk("t6_fd_flush_low", 64'(flush_done), 64'd0);
        flush = 1'b1;
        step();
        chk("t6_fd_reset", 64'(flush_done), 64'd1);
        set_push(64'h7000, 64'h70);
        step(); evict_push = 1'b0;
        chk("t6_fd_push_drop", 64'(flush_done), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
